// File: rtl/tone_note_detector.sv
// tone_note_detector: measures the rising-edge period of a square-wave tone,
// classifies it against eight note periods and locks after repeated matches.
// Optional macro TONE_NOTE_DUTY_CHECK_EN adds a 37.5%..62.5% duty-cycle gate.
// Ports: basys_clock, rst_n (sync, active-low), tone_in (async),
//   note_valid, note_code[3:0], note[31:0] (ASCII), note_start, period_out[31:0].
module tone_note_detector #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned STABLE_COUNT   = 4,
  parameter int unsigned SILENCE_CYCLES = 5_000_000,
  parameter int unsigned TOL_SHIFT      = 6
) (
  input  logic        basys_clock,
  input  logic        rst_n,
  input  logic        tone_in,
  output logic        note_valid,
  output logic [3:0]  note_code,
  output logic [31:0] note,
  output logic        note_start,
  output logic [31:0] period_out
);

  typedef enum logic [1:0] {
    IDLE, ARM, MEASURE, LOCKED
  } state_t;

  localparam logic [31:0] N_C  = 32'(CLK_FREQ / 256);
  localparam logic [31:0] N_E  = 32'(CLK_FREQ / 329);
  localparam logic [31:0] N_A  = 32'(CLK_FREQ / 440);
  localparam logic [31:0] N_B  = 32'(CLK_FREQ / 494);
  localparam logic [31:0] N_CH = 32'(CLK_FREQ / 523);
  localparam logic [31:0] N_DH = 32'(CLK_FREQ / 587);
  localparam logic [31:0] N_ES = 32'(CLK_FREQ / 622);
  localparam logic [31:0] N_EH = 32'(CLK_FREQ / 659);
  localparam logic [31:0] SIL_LAST = 32'(SILENCE_CYCLES - 1);
  localparam logic [3:0]  STABLE = 4'(STABLE_COUNT);

  logic        sync1, sync2, sync2_d;
  logic        edge_det;
  logic [31:0] pcnt;
  logic [31:0] meas;
  logic        duty_ok;
  logic [3:0]  cls;

  state_t      state, state_n;
  logic [3:0]  cand, cand_n;
  logic [3:0]  scnt, scnt_n;
  logic        start_q, start_n;

  function automatic logic in_win(
    input logic [31:0] p,
    input logic [31:0] n
  );
    return (p >= n - (n >> TOL_SHIFT)) &&
           (p <= n + (n >> TOL_SHIFT));
  endfunction

  assign edge_det = sync2 & ~sync2_d;
  assign meas     = (&pcnt) ? pcnt : pcnt + 32'd1;

  always_ff @(posedge basys_clock) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync2_d    <= 1'b0;
      pcnt       <= '0;
      period_out <= '0;
    end else begin
      sync1   <= tone_in;
      sync2   <= sync1;
      sync2_d <= sync2;
      if (edge_det) begin
        pcnt <= '0;
        // The arming edge closes no period.
        if (state != IDLE)
          period_out <= meas;
      end else if (!(&pcnt)) begin
        pcnt <= pcnt + 32'd1;
      end
    end
  end

`ifdef TONE_NOTE_DUTY_CHECK_EN
  logic [31:0] hcnt;
  logic [34:0] h8, p3, p5;

  // The edge cycle itself is high and belongs to the new period.
  always_ff @(posedge basys_clock) begin
    if (!rst_n)
      hcnt <= '0;
    else if (edge_det)
      hcnt <= 32'd1;
    else if (sync2 && !(&hcnt))
      hcnt <= hcnt + 32'd1;
  end

  assign h8      = {hcnt, 3'b000};
  assign p3      = 35'(meas) * 35'd3;
  assign p5      = 35'(meas) * 35'd5;
  assign duty_ok = (h8 >= p3) && (h8 <= p5);
`else
  assign duty_ok = 1'b1;
`endif

  always_comb begin
    cls = 4'd0;
    if (duty_ok) begin
      unique case (1'b1)
        in_win(meas, N_C):  cls = 4'd1;
        in_win(meas, N_E):  cls = 4'd2;
        in_win(meas, N_A):  cls = 4'd3;
        in_win(meas, N_B):  cls = 4'd4;
        in_win(meas, N_CH): cls = 4'd5;
        in_win(meas, N_DH): cls = 4'd6;
        in_win(meas, N_ES): cls = 4'd7;
        in_win(meas, N_EH): cls = 4'd8;
        default:            cls = 4'd0;
      endcase
    end
  end

  always_ff @(posedge basys_clock) begin
    if (!rst_n) begin
      state   <= IDLE;
      cand    <= '0;
      scnt    <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_n;
      cand    <= cand_n;
      scnt    <= scnt_n;
      start_q <= start_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    scnt_n  = scnt;
    start_n = 1'b0;
    if (edge_det) begin
      unique case (state)
        IDLE: begin
          state_n = ARM;
          cand_n  = '0;
          scnt_n  = '0;
        end
        LOCKED: begin
          if (cls != cand) begin
            state_n = MEASURE;
            cand_n  = cls;
            scnt_n  = {3'b000, cls != 4'd0};
          end
        end
        default: begin
          state_n = MEASURE;
          if (state == MEASURE && cls == cand && cls != 4'd0) begin
            scnt_n = scnt + 4'd1;
          end else begin
            cand_n = cls;
            scnt_n = {3'b000, cls != 4'd0};
          end
        end
      endcase
      if (state != IDLE && state_n == MEASURE && scnt_n == STABLE) begin
        state_n = LOCKED;
        start_n = 1'b1;
      end
    end else if (state != IDLE && pcnt == SIL_LAST) begin
      state_n = IDLE;
      cand_n  = '0;
      scnt_n  = '0;
    end
  end

  always_comb begin
    note_valid = (state == LOCKED);
    note_code  = note_valid ? cand : 4'd0;
    note_start = start_q;
    unique case (note_code)
      4'd1:    note = 32'h0000_0063;
      4'd2:    note = 32'h0000_0065;
      4'd3:    note = 32'h0000_0061;
      4'd4:    note = 32'h0000_0062;
      4'd5:    note = 32'h0000_6348;
      4'd6:    note = 32'h0000_6448;
      4'd7:    note = 32'h0000_6553;
      4'd8:    note = 32'h0000_6548;
      default: note = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_tone_note_detector.sv
// tb_tone_note_detector: directed bench for tone_note_detector.
// Scaled clock (250 kHz) keeps note periods short.
module tb_tone_note_detector;

  localparam int SIL = 2000;

  logic        basys_clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        tone_in = 1'b0;
  logic        note_valid;
  logic [3:0]  note_code;
  logic [31:0] note;
  logic        note_start;
  logic [31:0] period_out;

  int n_pass = 0;
  int n_total = 0;
  int ncyc = 0;

  int rises[$];
  int starts[$];
  int codes[$];
  int notes[$];
  int falls[$];
  bit seen_valid = 1'b0;
  bit prev_valid = 1'b0;
  bit prev_start = 1'b0;
  int dbl_start = 0;

  tone_note_detector #(
    .CLK_FREQ(250_000),
    .STABLE_COUNT(4),
    .SILENCE_CYCLES(SIL),
    .TOL_SHIFT(6)
  ) dut (
    .basys_clock(basys_clock),
    .rst_n(rst_n),
    .tone_in(tone_in),
    .note_valid(note_valid),
    .note_code(note_code),
    .note(note),
    .note_start(note_start),
    .period_out(period_out)
  );

  always #5 basys_clock = ~basys_clock;

  always @(posedge basys_clock) ncyc++;

  always @(negedge basys_clock) begin
    if (note_start) begin
      starts.push_back(ncyc);
      codes.push_back(int'(note_code));
      notes.push_back(int'(note));
    end
    if (prev_valid && !note_valid) falls.push_back(ncyc);
    if (note_valid) seen_valid = 1'b1;
    if (note_start && prev_start) dbl_start++;
    prev_valid = note_valid;
    prev_start = note_start;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  tag, got, got, exp, exp);
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    rises.delete();
    starts.delete();
    codes.delete();
    notes.delete();
    falls.delete();
    seen_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge basys_clock);
    rst_n = 1'b0;
    tone_in = 1'b0;
    repeat (3) @(negedge basys_clock);
    clear_logs();
    rst_n = 1'b1;
    @(negedge basys_clock);
  endtask

  task automatic tone(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      tone_in = 1'b1;
      rises.push_back(ncyc);
      repeat (hi) @(negedge basys_clock);
      tone_in = 1'b0;
      repeat (per - hi) @(negedge basys_clock);
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge basys_clock);
    check("rst_valid", int'(note_valid), 0);
    check("rst_code", int'(note_code), 0);
    check("rst_note", int'(note), 0);
    check("rst_start", int'(note_start), 0);
    check("rst_period", int'(period_out), 0);

    // eH lock: arm edge + 4 periods of 379
    do_reset();
    tone(379, 189, 6);
    check("eh_nstart", starts.size(), 1);
    check("eh_start_cyc", qat(starts, 0), qat(rises, 4) + 3);
    check("eh_valid", int'(note_valid), 1);
    check("eh_code", int'(note_code), 8);
    check("eh_note", int'(note), 32'h6548);
    check("eh_period", int'(period_out), 379);

    // eS lock, then eH takes over
    do_reset();
    tone(401, 200, 4);
    tone(379, 189, 4);
    tone(379, 189, 1);
    check("es_nstart", starts.size(), 2);
    check("es_start_cyc", qat(starts, 0), qat(rises, 4) + 3);
    check("es_code", qat(codes, 0), 7);
    check("es_note", qat(notes, 0), 32'h6553);
    check("es_drop_cyc", qat(falls, 0), qat(rises, 5) + 3);
    check("es2eh_start_cyc", qat(starts, 1), qat(rises, 8) + 3);
    check("es2eh_code", qat(codes, 1), 8);
    check("es2eh_note", qat(notes, 1), 32'h6548);

    // silence after the eH lock
    for (int i = 0; i < SIL + 200 && falls.size() < 2; i++)
      @(negedge basys_clock);
    check("sil_cyc", qat(falls, 1), qat(rises, 8) + 3 + SIL);
    check("sil_valid", int'(note_valid), 0);
    check("sil_code", int'(note_code), 0);
    check("sil_note", int'(note), 0);
    check("sil_period", int'(period_out), 379);

    // periods between windows never lock
    do_reset();
    tone(370, 185, 8);
    check("gap_p370", int'(period_out), 370);
    tone(390, 195, 8);
    tone(370, 185, 1);
    repeat (5) @(negedge basys_clock);
    check("gap_p390", int'(period_out), 390);
    check("gap_never_valid", int'(seen_valid), 0);
    check("gap_nstart", starts.size(), 0);

    // lock c, mid-note reset, relock
    do_reset();
    tone(976, 488, 5);
    check("c_code", int'(note_code), 1);
    check("c_note", int'(note), 32'h63);
    check("c_period", int'(period_out), 976);
    tone_in = 1'b1;
    repeat (100) @(negedge basys_clock);
    rst_n = 1'b0;
    tone_in = 1'b0;
    @(negedge basys_clock);
    check("mrst_valid", int'(note_valid), 0);
    check("mrst_code", int'(note_code), 0);
    check("mrst_note", int'(note), 0);
    check("mrst_period", int'(period_out), 0);
    clear_logs();
    rst_n = 1'b1;
    @(negedge basys_clock);
    tone(976, 488, 5);
    check("c_relock_n", starts.size(), 1);
    check("c_relock_cyc", qat(starts, 0), qat(rises, 4) + 3);
    check("c_relock_code", qat(codes, 0), 1);

    // 440 Hz at 20% duty, then 50%
    do_reset();
    tone(568, 114, 6);
`ifdef TONE_NOTE_DUTY_CHECK_EN
    check("a20_never_valid", int'(seen_valid), 0);
`else
    check("a20_code", int'(note_code), 3);
`endif
    do_reset();
    tone(568, 284, 6);
    check("a50_code", int'(note_code), 3);
    check("a50_note", int'(note), 32'h61);
    check("a50_start_cyc", qat(starts, 0), qat(rises, 4) + 3);

    check("start_one_cycle", dbl_start, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
